// File: rtl/arm_control_unit.sv
// arm_control_unit: single-cycle LEGv8 PC, decode and branch-resolution unit
module arm_control_unit #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [63:0] instr_addr,
  input  logic [31:0] instr,
  output logic [4:0]  Rd,
  output logic [4:0]  Rm,
  output logic [4:0]  Rn,
  output logic [4:0]  X30,
  output logic [63:0] PCPlusFour,
  output logic [8:0]  DAddr9,
  output logic [11:0] ALUImm12,
  output logic        Reg2Loc,
  output logic        ALUSrc,
  output logic        MemToReg,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        Rd_X30,
  output logic [2:0]  ALUOp,
  input  logic        flag_neg,
  input  logic        flag_zero,
  input  logic        flag_overf,
  input  logic        flag_cOut,
  input  logic [63:0] Db_ext,
  output logic        halted
);
  typedef enum logic [1:0] {S_RESET, S_RUN, S_HALT} state_e;
  state_e      state_q;
  logic [63:0] pc_q, pc_d, off;
  logic [3:0]  flags_q;
  logic        is_addi, is_adds, is_subs, is_ldur, is_stur, is_cbz, is_bcond, is_b, is_bl, is_br;
  logic        valid, en, cond_ok, taken, unused_c;
  assign is_addi  = instr[31:22] == 10'b1001000100;
  assign is_adds  = instr[31:21] == 11'b10101011000;
  assign is_subs  = instr[31:21] == 11'b11101011000;
  assign is_ldur  = instr[31:21] == 11'b11111000010;
  assign is_stur  = instr[31:21] == 11'b11111000000;
  assign is_cbz   = instr[31:24] == 8'b10110100;
  assign is_bcond = instr[31:24] == 8'b01010100;
  assign is_b     = instr[31:26] == 6'b000101;
  assign is_bl    = instr[31:26] == 6'b100101;
  assign is_br    = instr[31:21] == 11'b11010110000;
  assign valid = is_addi | is_adds | is_subs | is_ldur | is_stur | is_cbz | is_bcond | is_b | is_bl | is_br;
  assign halted = reset_n & ((state_q == S_HALT) | ~valid);
  assign en = reset_n & ~halted;
  assign Rd = is_br ? instr[9:5] : instr[4:0];
  assign Rn = instr[9:5];
  assign Rm = instr[20:16];
  assign X30 = 5'd30;
  assign DAddr9 = instr[20:12];
  assign ALUImm12 = instr[21:10];
  assign instr_addr = pc_q;
  assign PCPlusFour = pc_q + 64'd4;
  assign Reg2Loc = is_addi | is_adds | is_subs;
  assign ALUSrc = is_addi | is_ldur | is_stur;
  assign ALUOp = (is_addi | is_adds | is_ldur | is_stur) ? 3'b010 : is_subs ? 3'b011 : 3'b000;
  assign RegWrite = en & (is_addi | is_adds | is_subs | is_ldur | is_bl);
  assign MemWrite = en & is_stur;
  assign MemToReg = en & is_ldur;
  assign Rd_X30 = en & is_bl;
  // flags_q is {N,Z,V,C}; only N, Z and V feed the supported conditions
  assign cond_ok = instr[3:0] == 4'h0 ? flags_q[2] :
                   instr[3:0] == 4'h1 ? ~flags_q[2] :
                   instr[3:0] == 4'hA ? flags_q[3] == flags_q[1] :
                   instr[3:0] == 4'hB ? flags_q[3] != flags_q[1] : 1'b0;
  assign unused_c = flags_q[0];
  assign taken = is_b | is_bl | (is_cbz & flag_zero) | (is_bcond & cond_ok);
  assign off = (is_b | is_bl) ? {{36{instr[25]}}, instr[25:0], 2'b00} : {{43{instr[23]}}, instr[23:5], 2'b00};
  assign pc_d = halted ? pc_q : is_br ? Db_ext : taken ? pc_q + off : pc_q + 64'd4;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      flags_q <= 4'b0000;
    end else begin
      state_q <= (state_q == S_HALT || !valid) ? S_HALT : S_RUN;
      pc_q    <= pc_d;
      if (en && (is_adds || is_subs)) flags_q <= {flag_neg, flag_zero, flag_overf, flag_cOut};
    end
  end
endmodule

// File: tb/tb_arm_control_unit.sv
// tb_arm_control_unit: directed vector table plus randomized model comparison
module tb_arm_control_unit;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] instr_addr, PCPlusFour, Db_ext;
  logic [31:0] instr;
  logic [4:0]  Rd, Rm, Rn, X30;
  logic [8:0]  DAddr9;
  logic [11:0] ALUImm12;
  logic        Reg2Loc, ALUSrc, MemToReg, RegWrite, MemWrite, Rd_X30, halted;
  logic [2:0]  ALUOp;
  logic        flag_neg, flag_zero, flag_overf, flag_cOut;
  int vectors = 0;
  int miscompares = 0;

  arm_control_unit #(.RESET_PC(64'd0)) dut (
    .clk(clk), .reset_n(reset_n), .instr_addr(instr_addr), .instr(instr),
    .Rd(Rd), .Rm(Rm), .Rn(Rn), .X30(X30), .PCPlusFour(PCPlusFour),
    .DAddr9(DAddr9), .ALUImm12(ALUImm12), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .MemWrite(MemWrite), .Rd_X30(Rd_X30),
    .ALUOp(ALUOp), .flag_neg(flag_neg), .flag_zero(flag_zero), .flag_overf(flag_overf),
    .flag_cOut(flag_cOut), .Db_ext(Db_ext), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  nzvc;
    logic [63:0] db;
    logic [63:0] pc;
    logic [63:0] npc;
    logic [8:0]  ctl;
    logic [4:0]  rd;
    logic        hlt;
  } vec_t;

  // ctl = {Reg2Loc, ALUSrc, MemToReg, RegWrite, MemWrite, Rd_X30, ALUOp}
  localparam logic [8:0] C_ADDI = 9'b110100_010;
  localparam logic [8:0] C_ADDS = 9'b100100_010;
  localparam logic [8:0] C_SUBS = 9'b100100_011;
  localparam logic [8:0] C_LDUR = 9'b011100_010;
  localparam logic [8:0] C_STUR = 9'b010010_010;
  localparam logic [8:0] C_BL   = 9'b000101_000;
  localparam logic [8:0] C_NONE = 9'b000000_000;

  function automatic logic [31:0] e_addi(int rd, int rn, int imm);
    return {10'b1001000100, 12'(imm), 5'(rn), 5'(rd)};
  endfunction
  function automatic logic [31:0] e_adds(int rd, int rn, int rm);
    return {11'b10101011000, 5'(rm), 6'd0, 5'(rn), 5'(rd)};
  endfunction
  function automatic logic [31:0] e_subs(int rd, int rn, int rm);
    return {11'b11101011000, 5'(rm), 6'd0, 5'(rn), 5'(rd)};
  endfunction
  function automatic logic [31:0] e_ldur(int rt, int rn, int d9);
    return {11'b11111000010, 9'(d9), 2'b00, 5'(rn), 5'(rt)};
  endfunction
  function automatic logic [31:0] e_stur(int rt, int rn, int d9);
    return {11'b11111000000, 9'(d9), 2'b00, 5'(rn), 5'(rt)};
  endfunction
  function automatic logic [31:0] e_cbz(int imm, int rt);
    return {8'b10110100, 19'(imm), 5'(rt)};
  endfunction
  function automatic logic [31:0] e_bcond(int imm, int c);
    return {8'b01010100, 19'(imm), 1'b0, 4'(c)};
  endfunction
  function automatic logic [31:0] e_b(int imm);
    return {6'b000101, 26'(imm)};
  endfunction
  function automatic logic [31:0] e_bl(int imm);
    return {6'b100101, 26'(imm)};
  endfunction
  function automatic logic [31:0] e_br(int rn);
    return {11'b11010110000, 5'b11111, 6'd0, 5'(rn), 5'd0};
  endfunction

  function automatic vec_t mk(logic [31:0] ins, logic [3:0] nzvc, logic [63:0] db,
                              logic [63:0] pc, logic [63:0] npc, logic [8:0] ctl, logic hlt);
    vec_t v;
    v.ins = ins; v.nzvc = nzvc; v.db = db; v.pc = pc; v.npc = npc;
    v.ctl = ctl; v.rd = ins[4:0]; v.hlt = hlt;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // Starts and ends at a negedge; checks decode before the edge and the PC after it
  task automatic apply(vec_t v, string nm);
    instr = v.ins;
    {flag_neg, flag_zero, flag_overf, flag_cOut} = v.nzvc;
    Db_ext = v.db;
    #1;
    chk({nm, " pc"}, instr_addr, v.pc);
    chk({nm, " pc4"}, PCPlusFour, v.pc + 64'd4);
    chk({nm, " ctl"}, {Reg2Loc, ALUSrc, MemToReg, RegWrite, MemWrite, Rd_X30, ALUOp}, v.ctl);
    chk({nm, " rd"}, Rd, v.rd);
    chk({nm, " fields"}, {Rn, Rm, DAddr9, ALUImm12}, {v.ins[9:5], v.ins[20:16], v.ins[20:12], v.ins[21:10]});
    chk({nm, " halted"}, halted, v.hlt);
    @(posedge clk);
    #1;
    chk({nm, " npc"}, instr_addr, v.npc);
    @(negedge clk);
  endtask

  vec_t tbl[20];
  vec_t v;
  logic [63:0] mpc;
  logic        mn, mz, mv;

  initial begin
    tbl[0]  = mk(e_addi(1, 2, 5),        4'b0000, 0, 64'h00,  64'h04,  C_ADDI, 0);
    tbl[1]  = mk(e_addi(3, 4, 7),        4'b0000, 0, 64'h04,  64'h08,  C_ADDI, 0);
    tbl[2]  = mk(e_addi(5, 6, 9),        4'b0000, 0, 64'h08,  64'h0C,  C_ADDI, 0);
    tbl[3]  = mk(e_b(4),                 4'b0000, 0, 64'h0C,  64'h1C,  C_NONE, 0);
    tbl[4]  = mk(e_subs(7, 8, 9),        4'b1000, 0, 64'h1C,  64'h20,  C_SUBS, 0);
    tbl[5]  = mk(e_bcond(-2, 'hB),       4'b0111, 0, 64'h20,  64'h18,  C_NONE, 0);
    tbl[6]  = mk(e_b(2),                 4'b0000, 0, 64'h18,  64'h20,  C_NONE, 0);
    tbl[7]  = mk(e_bcond(-2, 'hA),       4'b0111, 0, 64'h20,  64'h24,  C_NONE, 0);
    tbl[8]  = mk(e_bcond(5, 'h0),        4'b0100, 0, 64'h24,  64'h28,  C_NONE, 0);
    tbl[9]  = mk(e_b(6),                 4'b0000, 0, 64'h28,  64'h40,  C_NONE, 0);
    tbl[10] = mk(e_cbz(3, 9),            4'b0100, 0, 64'h40,  64'h4C,  C_NONE, 0);
    tbl[11] = mk(e_b(-3),                4'b0000, 0, 64'h4C,  64'h40,  C_NONE, 0);
    tbl[12] = mk(e_cbz(3, 9),            4'b1011, 0, 64'h40,  64'h44,  C_NONE, 0);
    tbl[13] = mk(e_b(47),                4'b0000, 0, 64'h44,  64'h100, C_NONE, 0);
    tbl[14] = mk(e_bl(16),               4'b0000, 0, 64'h100, 64'h140, C_BL,   0);
    tbl[15] = mk(e_br(30),               4'b0000, 64'h104, 64'h140, 64'h104, C_NONE, 0);
    tbl[15].rd = 5'd30;
    tbl[16] = mk(e_ldur(3, 4, 'h1AB),    4'b0000, 0, 64'h104, 64'h108, C_LDUR, 0);
    tbl[17] = mk(e_stur(5, 6, 'h0F3),    4'b0000, 0, 64'h108, 64'h10C, C_STUR, 0);
    tbl[18] = mk(e_b(-55),               4'b0000, 0, 64'h10C, 64'h30,  C_NONE, 0);
    tbl[19] = mk(32'h0,                  4'b0000, 0, 64'h30,  64'h30,  C_NONE, 1);

    reset_n = 1'b0;
    instr = e_stur(1, 2, 3);
    {flag_neg, flag_zero, flag_overf, flag_cOut} = 4'b0000;
    Db_ext = 64'h0;
    #3;
    chk("reset pc", instr_addr, 64'h0);
    chk("reset strobes", {RegWrite, MemWrite, MemToReg, Rd_X30}, 4'b0000);
    chk("reset halted", halted, 1'b0);
    chk("x30", X30, 5'd30);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // PC stays parked and writes stay suppressed while halted
    for (int i = 0; i < 5; i++) apply(mk(e_addi(1, 1, 1), 4'b0000, 0, 64'h30, 64'h30, 9'b110000_010, 1), "halt");

    // asynchronous reset in the middle of a cycle
    instr = e_addi(2, 3, 4);
    #2 reset_n = 1'b0;
    #1;
    chk("async pc", instr_addr, 64'h0);
    chk("async halted", halted, 1'b0);
    chk("async regwrite", RegWrite, 1'b0);
    @(posedge clk);
    #1;
    chk("held pc", instr_addr, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    apply(mk(e_addi(2, 3, 4), 4'b0000, 0, 64'h00, 64'h04, C_ADDI, 0), "post addi");
    apply(mk(e_bcond(-1, 'hB), 4'b1000, 0, 64'h04, 64'h08, C_NONE, 0), "post blt");
    apply(mk(e_bcond(2, 'h1), 4'b0100, 0, 64'h08, 64'h10, C_NONE, 0), "post bne");

    // randomized run against a model that tracks PC and N/Z/V at instruction level
    mpc = 64'h10; mn = 0; mz = 0; mv = 0;
    for (int n = 0; n < 400; n++) begin
      int k, ra, rb, rc, c;
      logic [3:0]  live;
      logic [18:0] i19;
      logic [25:0] i26;
      longint      o;
      logic        t;
      k = $urandom_range(0, 9);
      ra = $urandom_range(0, 31); rb = $urandom_range(0, 31); rc = $urandom_range(0, 31);
      live = 4'($urandom);
      i19 = 19'($urandom);
      i26 = 26'($urandom);
      v = mk(32'h0, live, {$urandom, $urandom}, mpc, mpc + 64'd4, C_NONE, 0);
      case (k)
        0: begin v.ins = e_addi(ra, rb, int'($urandom_range(0, 4095))); v.ctl = C_ADDI; end
        1: begin v.ins = e_adds(ra, rb, rc); v.ctl = C_ADDS; end
        2: begin v.ins = e_subs(ra, rb, rc); v.ctl = C_SUBS; end
        3: begin v.ins = e_ldur(ra, rb, int'($urandom_range(0, 511))); v.ctl = C_LDUR; end
        4: begin v.ins = e_stur(ra, rb, int'($urandom_range(0, 511))); v.ctl = C_STUR; end
        5: begin
          v.ins = e_cbz(int'(i19), ra);
          o = i19[18] ? longint'(i19) - 524288 : longint'(i19);
          if (live[2]) v.npc = mpc + 64'(o * 4);
        end
        6: begin
          c = $urandom_range(0, 4);
          c = c == 0 ? 0 : c == 1 ? 1 : c == 2 ? 'hA : c == 3 ? 'hB : int'($urandom_range(0, 15));
          v.ins = e_bcond(int'(i19), c);
          o = i19[18] ? longint'(i19) - 524288 : longint'(i19);
          t = c == 0 ? mz : c == 1 ? !mz : c == 'hA ? (mn == mv) : c == 'hB ? (mn != mv) : 1'b0;
          if (t) v.npc = mpc + 64'(o * 4);
        end
        7, 8: begin
          v.ins = k == 7 ? e_b(int'(i26)) : e_bl(int'(i26));
          v.ctl = k == 7 ? C_NONE : C_BL;
          o = i26[25] ? longint'(i26) - 67108864 : longint'(i26);
          v.npc = mpc + 64'(o * 4);
        end
        default: begin v.ins = e_br(ra); v.npc = v.db; end
      endcase
      v.rd = k == 9 ? 5'(ra) : v.ins[4:0];
      apply(v, $sformatf("rand%0d k%0d", n, k));
      if (k == 1 || k == 2) {mn, mz, mv} = live[3:1];
      mpc = v.npc;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/arm_control_unit.md
# arm_control_unit

Single-cycle LEGv8 control and program-counter unit that drives the 64-bit register/ALU/data-memory datapath from the instruction side. It holds the PC, fetches a 32-bit instruction word from the combinational instruction memory, and decodes it into register addresses, immediates and control strobes for the datapath. It consumes the datapath's ALU flags and `Db_ext` to resolve branches, and keeps a registered NZVC flag set for conditional branches.

## Interface
- `RESET_PC`, default 64'd0, PC value loaded on reset.
- `clk` in 1: system clock; all state updates on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `instr_addr` out 64: current PC, driven to instruction memory.
- `instr` in 32: instruction word at `instr_addr`, combinational from instruction memory.
- `Rd`, `Rm`, `Rn` out 5 each: register fields to the datapath.
- `X30` out 5: constant 5'd30.
- `PCPlusFour` out 64: `instr_addr + 4`, link value for BL.
- `DAddr9` out 9: `instr[20:12]`.
- `ALUImm12` out 12: `instr[21:10]`.
- `Reg2Loc`, `ALUSrc`, `MemToReg`, `RegWrite`, `MemWrite`, `Rd_X30` out 1 each: datapath controls.
- `ALUOp` out 3: 000 pass B, 010 add, 011 sub.
- `flag_neg`, `flag_zero`, `flag_overf`, `flag_cOut` in 1 each: live ALU flags.
- `Db_ext` in 64: register read port B value, used as the BR target.
- `halted` out 1: high once an unrecognized opcode has been reached.

## Operation
- Default fields: `Rd=instr[4:0]`, `Rn=instr[9:5]`, `Rm=instr[20:16]`. For BR only, `Rd=instr[9:5]`, so that port B reads the target register.
- Decode, with unlisted strobes at 0:
  - ADDI (`instr[31:22]`=1001000100): Reg2Loc=1, ALUSrc=1, ALUOp=010, RegWrite=1.
  - ADDS (`[31:21]`=10101011000): Reg2Loc=1, ALUOp=010, RegWrite=1, flags latch.
  - SUBS (11101011000): same as ADDS with ALUOp=011, flags latch.
  - LDUR (11111000010): ALUSrc=1, ALUOp=010, MemToReg=1, RegWrite=1.
  - STUR (11111000000): ALUSrc=1, ALUOp=010, MemWrite=1.
  - CBZ (`[31:24]`=10110100): ALUOp=000. Taken iff live `flag_zero`.
  - B.cond (`[31:24]`=01010100): no writes. Cond `instr[3:0]`: 0 EQ (Z), 1 NE (!Z), 0xA GE (N==V), 0xB LT (N!=V). Evaluated on the registered flags. Any other cond is not taken.
  - B (`[31:26]`=000101): taken unconditionally.
  - BL (100101): taken unconditionally, with RegWrite=1 and Rd_X30=1.
  - BR (`[31:21]`=11010110000): next PC = `Db_ext`.
- Branch targets: B/BL use PC + (sext(`instr[25:0]`) << 2). CBZ/B.cond use PC + (sext(`instr[23:5]`) << 2). Arithmetic is 64-bit modulo 2^64, and the PC wraps.
- Next PC is the taken target, `Db_ext` for BR, or PC+4 otherwise.
- Unrecognized opcode: state goes RUN→HALT. Once `halted` is set (including the cycle of the bad opcode itself), all strobes (RegWrite, MemWrite, MemToReg, Rd_X30) are forced to 0 and the PC holds.
- FSM states:
  - RESET→RUN on `reset_n` release.
  - RUN→HALT on an unrecognized opcode.
  - HALT is exited only by reset.
- Flag register: {N,Z,V,C} latches the live flags on posedge when the current instruction is ADDS or SUBS. No other instruction modifies it.

## Timing
- Decode and strobes are combinational from `instr` and state. PC, flag register and state are registered: single-cycle execution, one instruction per clock.
- Reset values (asserted asynchronously, held while `reset_n`=0):
  - `instr_addr`=RESET_PC, flags=0000, state=RUN after release, `halted`=0.
  - All write strobes are 0 while `reset_n`=0.
- Reset mid-execution: PC returns to RESET_PC immediately and no write is issued while held low. The first posedge after release executes the instruction at RESET_PC.
- B.cond reads flags as registered before the edge. ADDS followed by B.LT in the next cycle sees the ADDS result. ADDS and B.cond cannot occur in the same cycle.
- CBZ uses same-cycle live `flag_zero` (ALU pass-B of Rt).
- `halted` rises combinationally in the bad-opcode cycle and stays registered high from the next posedge.

## Test plan
- Reset: `reset_n`=0 with RESET_PC=0 → `instr_addr`=0, flags=0, RegWrite=MemWrite=0. Release it, and three sequential ADDI → `instr_addr` 0,4,8,12.
- SUBS with live N=1, V=0 → flag register 1000 after the edge. The next B.LT with imm19=-2 at PC=0x20 → PC=0x18. B.GE in the same situation → PC=0x24.
- CBZ at PC=0x40, imm19=3: `flag_zero`=1 → next PC=0x4C. `flag_zero`=0 → next PC=0x44. RegWrite=0 in both cases.
- BL at PC=0x100, imm26=0x10 → RegWrite=1, Rd_X30=1, PCPlusFour=0x104, next PC=0x140. Then BR with `instr[9:5]`=30 and `Db_ext`=0x104 → Rd=30, next PC=0x104.
- LDUR/STUR decode → LDUR gives MemToReg=1, RegWrite=1, ALUSrc=1, Reg2Loc=0. STUR gives MemWrite=1, RegWrite=0, `DAddr9`=`instr[20:12]`.
- `instr`=0 at PC=0x30 → `halted`=1 and all strobes 0, PC stays 0x30 for 5 cycles. Pulse `reset_n` low mid-cycle → PC=0 asynchronously, `halted`=0.
